// File: rtl/ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares two single-port RAM banks between two requesters (port 0, port 1).
// One access runs at a time. When both ports request together, the port that
// was not granted last wins. The winning command is registered as it is
// accepted, and the shared RAM bus is driven for exactly one ACCESS cycle.
// A read then waits RD_LAT cycles and captures the bank read data from the
// external read-output selector, which this block steers with ram_sel.
//
// Parameters
//   ADDR_W   per-bank word address width; requester address is ADDR_W+1 bits,
//            MSB selects the bank
//   DATA_W   data width of both banks
//   RD_LAT   bank read latency in cycles from the enable edge (>= 1)
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req0/1, we0/1        request (held until gnt), 1 = write / 0 = read
//   addr0/1, wdata0/1    {bank, word} address and write data per requester
//   gnt0/1               one-cycle pulse: command accepted
//   rvalid0/1, rdata0/1  one-cycle read-valid pulse; rdata held until next read
//   ram_en0/1            per-bank access strobe (one cycle)
//   ram_we, ram_addr     shared write enable and word address
//   ram_wdata            shared write data
//   ram_sel              read-output selector control (0 = bank 0, 1 = bank 1)
//   ram_rdata            selector output (selected bank read data)
//   busy                 high whenever an access is in progress
// -----------------------------------------------------------------------------
module ram_access_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W:0]   addr0,
    input  logic [ADDR_W:0]   addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en0,
    output logic              ram_en1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_sel,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    // The WAIT counter runs from RD_LAT-1 down to 0; keep at least one bit.
    localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    // State and bookkeeping
    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              port_q,     port_d;

    // Registered outputs
    logic              gnt0_q,      gnt0_d;
    logic              gnt1_q,      gnt1_d;
    logic              rvalid0_q,   rvalid0_d;
    logic              rvalid1_q,   rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,    rdata0_d;
    logic [DATA_W-1:0] rdata1_q,    rdata1_d;
    logic              ram_en0_q,   ram_en0_d;
    logic              ram_en1_q,   ram_en1_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_sel_q,   ram_sel_d;
    logic              busy_q,      busy_d;

    // Winner of the current IDLE edge and its command
    logic              win_port_s;
    logic              win_we_s;
    logic [ADDR_W:0]   win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Round-robin pick: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        win_port_s  = 1'b0;
        win_we_s    = 1'b0;
        win_addr_s  = {(ADDR_W + 1){1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        if (req0 && req1) begin
            win_port_s = ~last_gnt_q;
        end else if (req1) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
        if (win_port_s) begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
    end

    // Next-state and next-output logic for the IDLE / ACCESS / WAIT sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        port_d      = port_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        // Bus strobes and command fields are only non-zero during ACCESS.
        ram_en0_d   = 1'b0;
        ram_en1_d   = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = {ADDR_W{1'b0}};
        ram_wdata_d = {DATA_W{1'b0}};
        // The selector keeps pointing at the last bank until the next access.
        ram_sel_d   = ram_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d     = ST_ACCESS;
                    port_d      = win_port_s;
                    last_gnt_d  = win_port_s;
                    gnt0_d      = ~win_port_s;
                    gnt1_d      = win_port_s;
                    ram_en0_d   = ~win_addr_s[ADDR_W];
                    ram_en1_d   = win_addr_s[ADDR_W];
                    ram_we_d    = win_we_s;
                    ram_addr_d  = win_addr_s[ADDR_W-1:0];
                    ram_wdata_d = win_wdata_s;
                    ram_sel_d   = win_addr_s[ADDR_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // ram_we_q still holds the accepted command's write flag here.
                if (ram_we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                    if (port_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = ram_rdata;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            last_gnt_q  <= 1'b1;
            port_q      <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            ram_en0_q   <= 1'b0;
            ram_en1_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
            ram_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            port_q      <= port_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ram_en0_q   <= ram_en0_d;
            ram_en1_q   <= ram_en1_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_sel_q   <= ram_sel_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_en0   = ram_en0_q;
    assign ram_en1   = ram_en1_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_sel   = ram_sel_q;
    assign busy      = busy_q;

endmodule
